// File: rtl/exe_stage_if.sv
// Handshake and bus bundle between the ID, EX and MEM stages,
// plus the data-SRAM request and the ID bypass/stall signals.
interface exe_stage_if;
    logic         MEM_allow;
    logic         EX_allow;
    logic         ID_to_EX_valid;
    logic [150:0] ID_to_EX_bus;
    logic         EX_to_MEM_valid;
    logic [70:0]  EX_to_MEM_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [37:0]  EX_to_ID_forward;
    logic         EX_to_ID_load;

    modport master (
        output MEM_allow, ID_to_EX_valid, ID_to_EX_bus,
        input  EX_allow, EX_to_MEM_valid, EX_to_MEM_bus,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  EX_to_ID_forward, EX_to_ID_load
    );

    modport slave (
        input  MEM_allow, ID_to_EX_valid, ID_to_EX_bus,
        output EX_allow, EX_to_MEM_valid, EX_to_MEM_bus,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output EX_to_ID_forward, EX_to_ID_load
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, iterative restoring divider, data-SRAM
// request issue and EX->ID forwarding.
module exe_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    exe_stage_if.slave io
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;

    localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);

    logic         r_valid;
    logic [150:0] r_bus;
    div_state_t   r_state;
    div_state_t   w_next;
    logic [5:0]   r_cnt;
    logic [31:0]  r_rem;
    logic [31:0]  r_quo;
    logic [31:0]  r_dvsr;
    logic         r_s1neg;
    logic         r_s2neg;

    logic         w_div_en, w_div_signed, w_div_rem;
    logic [11:0]  w_op;
    logic         w_mem_we, w_rfm, w_gr_we;
    logic [4:0]   w_dest, w_sa;
    logic [31:0]  w_src1, w_src2, w_st, w_pc;
    logic         w_ready_go, w_allow, w_start;
    logic         w_s1neg, w_s2neg;
    logic [31:0]  w_abs1, w_abs2;
    logic [32:0]  w_rem_sh;
    logic         w_ge;
    logic [31:0]  w_diff;
    logic [31:0]  w_quo_f, w_rem_f;
    logic [31:0]  w_alu, w_result;
    logic         w_sram_en;

    assign {w_div_en, w_div_signed, w_div_rem, w_op, w_mem_we, w_rfm,
            w_gr_we, w_dest, w_src1, w_src2, w_st, w_pc} = r_bus;

    assign w_ready_go = !w_div_en || (r_state == S_DONE);
    assign w_allow    = !r_valid || (w_ready_go && io.MEM_allow);
    assign w_start    = (r_state == S_IDLE) && r_valid && w_div_en;

    always_ff @(posedge clk) begin
        if (reset)
            r_valid <= 1'b0;
        else if (w_allow)
            r_valid <= io.ID_to_EX_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset && io.ID_to_EX_valid && w_allow)
            r_bus <= io.ID_to_EX_bus;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_CALC;
            S_CALC: if (r_cnt == LAST) w_next = S_DONE;
            S_DONE: if (io.MEM_allow) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sign flags are only raised for signed divides, so fixup needs no mode bit.
    assign w_s1neg  = w_div_signed && w_src1[31];
    assign w_s2neg  = w_div_signed && w_src2[31];
    assign w_abs1   = w_s1neg ? -w_src1 : w_src1;
    assign w_abs2   = w_s2neg ? -w_src2 : w_src2;
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_ge     = w_rem_sh >= {1'b0, r_dvsr};
    assign w_diff   = w_rem_sh[31:0] - r_dvsr;

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_quo   <= w_abs1;
            r_dvsr  <= w_abs2;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_s1neg <= w_s1neg;
            r_s2neg <= w_s2neg;
        end else if (r_state == S_CALC) begin
            r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign w_quo_f = (r_s1neg ^ r_s2neg) ? -r_quo : r_quo;
    assign w_rem_f = r_s1neg ? -r_rem : r_rem;
    assign w_sa    = w_src2[4:0];

    always_comb begin
        w_alu = '0;
        unique case (1'b1)
            w_op[0]:  w_alu = w_src1 + w_src2;
            w_op[1]:  w_alu = w_src1 - w_src2;
            w_op[2]:  w_alu = {31'b0, $signed(w_src1) < $signed(w_src2)};
            w_op[3]:  w_alu = {31'b0, w_src1 < w_src2};
            w_op[4]:  w_alu = w_src1 & w_src2;
            w_op[5]:  w_alu = ~(w_src1 | w_src2);
            w_op[6]:  w_alu = w_src1 | w_src2;
            w_op[7]:  w_alu = w_src1 ^ w_src2;
            w_op[8]:  w_alu = w_src1 << w_sa;
            w_op[9]:  w_alu = w_src1 >> w_sa;
            w_op[10]: w_alu = $signed(w_src1) >>> w_sa;
            w_op[11]: w_alu = w_src2;
            default:  w_alu = '0;
        endcase
    end

    assign w_result = w_div_en ? (w_div_rem ? w_rem_f : w_quo_f) : w_alu;

    // Requests leave only on the handoff edge so MEM sees the data next cycle.
    assign w_sram_en = r_valid && w_ready_go && io.MEM_allow && (w_mem_we || w_rfm);

    assign io.EX_allow         = w_allow;
    assign io.EX_to_MEM_valid  = r_valid && w_ready_go;
    assign io.EX_to_MEM_bus    = {w_rfm, w_gr_we, w_dest, w_result, w_pc};
    assign io.data_sram_en     = w_sram_en;
    assign io.data_sram_we     = {4{w_sram_en && w_mem_we}};
    assign io.data_sram_addr   = w_alu;
    assign io.data_sram_wdata  = w_st;
    assign io.EX_to_ID_forward = {w_gr_we, w_dest & {5{r_valid}}, w_result};
    assign io.EX_to_ID_load    = r_valid && w_rfm;
endmodule
